// File: rtl/shift_register_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ASR   = 3'b101,
        MODE_LOAD  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_register_burst_ctrl.sv
// Burst sequencer: latches mode/count on start, strobes op_en once per enabled cycle, pulses done.
module shift_register_burst_ctrl
    import shift_register_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  mode_e            mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output mode_e            eff_mode,
    output logic             op_en,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        op_en       = 1'b0;
        eff_mode    = (state_q == ST_RUN) ? mode_q : mode;
        if (clken) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d = mode;
                        if (count != '0) begin
                            state_d     = ST_RUN;
                            remaining_d = count;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        op_en = 1'b1;
                    end
                end
                ST_RUN: begin
                    // mode, start and count are ignored while a burst runs
                    op_en       = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_HOLD;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: shift/rotate/ASR/load/clear, continuous or as a counted burst.
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      CNT_W   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             SI_L,
    input  logic             SI_R,
    input  logic [WIDTH-1:0] PI,
    output logic [WIDTH-1:0] PO,
    output logic             SO_L,
    output logic             SO_R,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_q, r_d;
    mode_e            eff_mode;
    logic             op_en;

    shift_register_burst_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .mode     (mode_e'(mode)),
        .start    (start),
        .count    (count),
        .eff_mode (eff_mode),
        .op_en    (op_en),
        .busy     (busy),
        .done     (done)
    );

    // Each arm references only the input it consumes, so unused X inputs stay out of PO
    always_comb begin
        r_d = r_q;
        if (op_en) begin
            case (eff_mode)
                MODE_HOLD:  r_d = r_q;
                MODE_SHL:   r_d = {r_q[WIDTH-2:0], SI_L};
                MODE_SHR:   r_d = {SI_R, r_q[WIDTH-1:1]};
                MODE_ROL:   r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_ROR:   r_d = {r_q[0], r_q[WIDTH-1:1]};
                MODE_ASR:   r_d = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                MODE_LOAD:  r_d = PI;
                MODE_CLEAR: r_d = '0;
                default:    r_d = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= r_d;
        end
    end

    assign PO   = r_q;
    assign SO_L = r_q[WIDTH-1];
    assign SO_R = r_q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor pops and compares each cycle.
module tb_shift_register_universal;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         clken;
    logic [2:0]   mode;
    logic         start;
    logic [5:0]   count;
    logic         SI_L;
    logic         SI_R;
    logic [W-1:0] PI;
    logic [W-1:0] PO;
    logic         SO_L;
    logic         SO_R;
    logic         busy;
    logic         done;

    shift_register_universal #(
        .WIDTH   (W),
        .CNT_W   (6),
        .RST_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clken (clken),
        .mode  (mode),
        .start (start),
        .count (count),
        .SI_L  (SI_L),
        .SI_R  (SI_R),
        .PI    (PI),
        .PO    (PO),
        .SO_L  (SO_L),
        .SO_R  (SO_R),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] po;
        logic         busy;
        logic         done;
        logic         has_fix;
        logic [W-1:0] fix;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register value plus number of burst operations still owed
    logic [W-1:0] m_reg  = '0;
    int           m_left = 0;
    logic [2:0]   m_bmode = '0;
    logic         m_done = 1'b0;

    function automatic logic [W-1:0] apply(input logic [2:0] md, input logic [W-1:0] r,
                                           input logic sl, input logic sr, input logic [W-1:0] p);
        case (md)
            3'd0:    return r;
            3'd1:    return (r << 1) | W'(sl);
            3'd2:    return (r >> 1) | (W'(sr) << (W - 1));
            3'd3:    return (r << 1) | (r >> (W - 1));
            3'd4:    return (r >> 1) | (r << (W - 1));
            3'd5:    return W'($signed(r) >>> 1);
            3'd6:    return p;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic i_rst, input logic i_clken, input logic [2:0] i_mode,
                        input logic i_start, input logic [5:0] i_count, input logic i_sil,
                        input logic i_sir, input logic [W-1:0] i_pi,
                        input logic fixv = 1'b0, input logic [W-1:0] fixval = '0);
        exp_t e;
        logic nd;
        @(negedge clk);
        rst = i_rst; clken = i_clken; mode = i_mode; start = i_start;
        count = i_count; SI_L = i_sil; SI_R = i_sir; PI = i_pi;
        if (i_rst) begin
            m_reg = 8'h00; m_left = 0; m_done = 1'b0;
        end else begin
            nd = 1'b0;
            if (i_clken) begin
                if (m_left == 0) begin
                    if (i_start) begin
                        m_bmode = i_mode;
                        if (i_count == 0) nd = 1'b1;
                        else m_left = int'(i_count);
                    end else begin
                        m_reg = apply(i_mode, m_reg, i_sil, i_sir, i_pi);
                    end
                end else begin
                    m_reg = apply(m_bmode, m_reg, i_sil, i_sir, i_pi);
                    m_left--;
                    if (m_left == 0) nd = 1'b1;
                end
            end
            m_done = nd;
        end
        e.po = m_reg; e.busy = (m_left != 0); e.done = m_done;
        e.has_fix = fixv; e.fix = fixval;
        sb.push_back(e);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 3'd0, 0, 6'd0, 0, 0, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("po",   PO,       e.po);
                check("busy", W'(busy), W'(e.busy));
                check("done", W'(done), W'(e.done));
                check("so_l", W'(SO_L), W'(e.po[W-1]));
                check("so_r", W'(SO_R), W'(e.po[0]));
                if (e.has_fix) check("po_directed", PO, e.fix);
            end
        end
    end

    initial begin : driver
        rst = 1'b1; clken = 1'b0; mode = '0; start = 1'b0; count = '0;
        SI_L = 1'b0; SI_R = 1'b0; PI = '0;

        step(1, 1, 3'd0, 0, 6'd0, 0, 0, 8'h00);
        step(1, 0, 3'd0, 0, 6'd0, 0, 0, 8'h00, 1, 8'h00);

        // Reset after load, then clken gating of LOAD
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'hFF, 1, 8'hFF);
        step(1, 0, 3'd6, 0, 6'd0, 0, 0, 8'hFF, 1, 8'h00);
        step(0, 0, 3'd6, 0, 6'd0, 0, 0, 8'h5A, 1, 8'h00);

        // SHL 1,0,(stall),1,1 -> 0B
        step(0, 1, 3'd1, 0, 6'd0, 1, 0, 8'h00, 1, 8'h01);
        step(0, 1, 3'd1, 0, 6'd0, 0, 0, 8'h00, 1, 8'h02);
        step(0, 0, 3'd1, 0, 6'd0, 1, 0, 8'h00, 1, 8'h02);
        step(0, 1, 3'd1, 0, 6'd0, 1, 0, 8'h00, 1, 8'h05);
        step(0, 1, 3'd1, 0, 6'd0, 1, 0, 8'h00, 1, 8'h0B);

        // Rotates and right shifts
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'hA5, 1, 8'hA5);
        step(0, 1, 3'd4, 0, 6'd0, 0, 0, 8'h00, 1, 8'hD2);
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'hA5);
        step(0, 1, 3'd3, 0, 6'd0, 0, 0, 8'h00, 1, 8'h4B);
        step(0, 1, 3'd3, 0, 6'd0, 0, 0, 8'h00, 1, 8'h96);
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'h80);
        step(0, 1, 3'd5, 0, 6'd0, 0, 0, 8'h00, 1, 8'hC0);
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'h80);
        step(0, 1, 3'd2, 0, 6'd0, 0, 0, 8'h00, 1, 8'h40);

        // Burst SHL x3; mode/start changes during RUN are ignored
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'h01);
        step(0, 1, 3'd1, 1, 6'd3, 0, 0, 8'h00, 1, 8'h01);
        step(0, 1, 3'd6, 1, 6'd7, 0, 0, 8'hFF, 1, 8'h02);
        step(0, 1, 3'd7, 1, 6'd1, 0, 1, 8'hFF, 1, 8'h04);
        step(0, 1, 3'd2, 0, 6'd2, 0, 1, 8'hFF, 1, 8'h08);
        hold(2);

        // Same burst with two stalled cycles in the middle
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'h01);
        step(0, 1, 3'd1, 1, 6'd3, 0, 0, 8'h00);
        step(0, 1, 3'd0, 0, 6'd0, 0, 0, 8'h00, 1, 8'h02);
        step(0, 0, 3'd6, 1, 6'd0, 1, 1, 8'hFF, 1, 8'h02);
        step(0, 0, 3'd6, 1, 6'd0, 1, 1, 8'hFF, 1, 8'h02);
        step(0, 1, 3'd0, 0, 6'd0, 0, 0, 8'h00, 1, 8'h04);
        step(0, 1, 3'd0, 0, 6'd0, 0, 0, 8'h00, 1, 8'h08);
        hold(2);

        // Zero-length burst
        step(0, 1, 3'd6, 1, 6'd0, 0, 0, 8'hFF, 1, 8'h08);
        hold(2);

        // Reset mid-burst: no done afterwards
        step(0, 1, 3'd6, 0, 6'd0, 0, 0, 8'h3C);
        step(0, 1, 3'd1, 1, 6'd5, 1, 0, 8'h00);
        step(0, 1, 3'd0, 0, 6'd0, 1, 0, 8'h00, 1, 8'h79);
        step(0, 1, 3'd0, 0, 6'd0, 1, 0, 8'h00, 1, 8'hF3);
        step(1, 1, 3'd0, 0, 6'd0, 1, 0, 8'h00, 1, 8'h00);
        hold(10);

        // Randomised traffic, including long bursts that wrap rotates
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0),
                 6'($urandom_range(0, 20)),
                 1'($urandom), 1'($urandom), 8'($urandom));
        end
        hold(25);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("sb_drained", W'(sb.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
